// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, memory write codes, FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] DMWR_NONE = 2'b00;
    localparam logic [1:0] DMWR_WORD = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StMergeWr,
        StResp
    } lsu_state_e;

    // Half needs addr[0] = 0, word (and the 11 alias) needs addr[1:0] = 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and sign/zero-extend it for loads.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_H:    load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Overlay the low byte/half of the store data onto the old word at its lane.
    always_comb begin
        merged = word;
        case (size)
            SZ_B: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store controller in front of a word-wide data memory; sub-word stores become
// read-modify-write so the memory only ever sees full-word writes.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int unsigned DM_AW = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_misalign,
    output logic [DM_AW-1:0] mem_addr,
    output logic [1:0]       mem_dmwr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    lsu_state_e       state_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       lo_q;
    logic [31:0]      wdata_q;
    logic [DM_AW-1:0] mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [1:0]       dmwr_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_mis_q;
    logic [31:0]      load_data;
    logic [31:0]      merged;

    // Address bits above the memory are intentionally dropped (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:DM_AW+2];

    lsu_lane_mux u_lane_mux (
        .word        (mem_rdata),
        .addr_lo     (lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Handshake flags follow the state; write strobe is killed while reset is held.
    always_comb begin
        req_ready     = (state_q == StIdle);
        resp_valid    = (state_q == StResp);
        resp_rdata    = resp_rdata_q;
        resp_misalign = resp_mis_q;
        mem_addr      = mem_addr_q;
        mem_wdata     = mem_wdata_q;
        mem_dmwr      = rst ? DMWR_NONE : dmwr_q;
    end

    // Controller FSM with registered memory-side and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            lo_q         <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dmwr_q       <= DMWR_NONE;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lo_q    <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            resp_mis_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= StResp;
                        end else begin
                            mem_addr_q <= req_addr[DM_AW+1:2];
                            state_q    <= StAccess;
                            // Word stores write straight away in ACCESS.
                            if (req_we && req_size[1]) begin
                                dmwr_q      <= DMWR_WORD;
                                mem_wdata_q <= req_wdata;
                            end
                        end
                    end
                end
                StAccess: begin
                    if (we_q && !size_q[1]) begin
                        mem_wdata_q <= merged;
                        dmwr_q      <= DMWR_WORD;
                        state_q     <= StMergeWr;
                    end else begin
                        if (!we_q) resp_rdata_q <= load_data;
                        dmwr_q      <= DMWR_NONE;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        state_q     <= StResp;
                    end
                end
                StMergeWr: begin
                    dmwr_q      <= DMWR_NONE;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_rdata_q <= '0;
                        resp_mis_q   <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word memory on the far side.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [6:0]  mem_addr;
    logic [1:0]  mem_dmwr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [128];
    int          wr_cnt = 0;
    int          bad_code_cnt = 0;
    logic [6:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsu_rmw #(.DM_AW(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_addr      (mem_addr),
        .mem_dmwr      (mem_dmwr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    // Memory model: word write on 01, count every write and any illegal code.
    always @(posedge clk) begin
        if (mem_dmwr == 2'b01) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (mem_dmwr[1]) bad_code_cnt <= bad_code_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction with resp_ready held high.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic mis,
                          output int nwr);
        int w0;
        w0           = wr_cnt;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        resp_ready   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = resp_rdata;
        mis = resp_misalign;
        @(posedge clk); #1;
        nwr = wr_cnt - w0;
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
        int lat, nwr;
        logic [31:0] rd;
        logic mis;
        do_req(1'b0, sz, uns, addr, 32'h0, lat, rd, mis, nwr);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_lat"}, lat, 2);
    endtask

    initial begin
        int          lat, nwr;
        logic [31:0] rd;
        logic        mis;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_mis", resp_misalign, 0);
        chk("rst_dmwr", mem_dmwr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Word store then load.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, mis, nwr);
        chk("sw_lat", lat, 2);
        chk("sw_nwr", nwr, 1);
        chk("sw_addr", wr_addr, 4);
        chk("sw_data", wr_data, 32'hDEADBEEF);
        chk("sw_rdata", rd, 0);
        load_chk("lw", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

        // Byte store via read-modify-write.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, mis, nwr);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, lat, rd, mis, nwr);
        chk("sb_lat", lat, 3);
        chk("sb_nwr", nwr, 1);
        chk("sb_addr", wr_addr, 4);
        chk("sb_data", wr_data, 32'h11AB3344);
        chk("sb_mem", mem[4], 32'h11AB3344);

        // Sign/zero extension.
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h8001F0FF, lat, rd, mis, nwr);
        load_chk("lb0", 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF);
        load_chk("lbu0", 2'b00, 1'b1, 32'h0, 32'h000000FF);
        load_chk("lh2", 2'b01, 1'b0, 32'h2, 32'hFFFF8001);
        load_chk("lhu2", 2'b01, 1'b1, 32'h2, 32'h00008001);
        load_chk("lb1", 2'b00, 1'b0, 32'h1, 32'hFFFFFFF0);
        load_chk("lbu3", 2'b00, 1'b1, 32'h3, 32'h00000080);
        load_chk("lh0", 2'b01, 1'b0, 32'h0, 32'hFFFFF0FF);
        load_chk("lw_sz11", 2'b11, 1'b0, 32'h0, 32'h8001F0FF);

        // Misaligned accesses.
        do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, lat, rd, mis, nwr);
        chk("mis_lh_lat", lat, 1);
        chk("mis_lh_flag", mis, 1);
        chk("mis_lh_rdata", rd, 0);
        chk("mis_lh_nwr", nwr, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678, lat, rd, mis, nwr);
        chk("mis_sw_lat", lat, 1);
        chk("mis_sw_flag", mis, 1);
        chk("mis_sw_rdata", rd, 0);
        chk("mis_sw_nwr", nwr, 0);
        load_chk("after_mis", 2'b10, 1'b0, 32'h0, 32'h8001F0FF);

        // Halfword store wrapping to word 0; upper store-data bits ignored.
        do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFFCAFE, lat, rd, mis, nwr);
        chk("sh_wrap_lat", lat, 3);
        chk("sh_wrap_addr", wr_addr, 0);
        chk("sh_wrap_data", wr_data, 32'hCAFEF0FF);

        // Backpressure: response held, competing request waits.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_size = 2'b00; req_unsigned = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 32'h11AB3344);
            chk("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", resp_valid, 0);
        chk("bp_hs_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_accepted", req_ready, 0);
        chk("bp_next_addr", mem_addr, 4);
        @(posedge clk); #1;
        chk("bp_next_valid", resp_valid, 1);
        chk("bp_next_rdata", resp_rdata, 32'h00000044);
        @(posedge clk); #1;

        // Reset during MERGE_WR of a halfword store.
        nwr = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mrg_dmwr", mem_dmwr, 1);
        rst = 1'b1;
        #1 chk("mrg_rst_dmwr", mem_dmwr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrg_rst_req_ready", req_ready, 1);
        chk("mrg_rst_valid", resp_valid, 0);
        chk("mrg_rst_nwr", wr_cnt - nwr, 0);
        chk("mrg_rst_mem", mem[4], 32'h11AB3344);
        load_chk("mrg_reload", 2'b10, 1'b0, 32'h10, 32'h11AB3344);

        chk("illegal_dmwr", bad_code_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store access controller sitting directly upstream of the data memory.
- Accepts CPU load/store requests of byte, half or word size over a valid/ready handshake.
- Drives the data memory's word port and implements sub-word stores as read-modify-write, so memory only ever receives full-word writes.
- Returns loads lane-extracted and sign/zero-extended, and flags misaligned accesses without touching memory.

Parameters:
- DM_AW, 7, memory word-address width; the memory address is req_addr[DM_AW+1:2].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_misalign  out  1  request was misaligned; no memory access performed.
- mem_addr  out  DM_AW  word address to data memory.
- mem_dmwr  out  2  memory write control: 00 = none, 01 = word write; never 10 or 11.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- Byte order is little-endian.
  - Byte lane = addr[1:0], occupying bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], occupying bits [16*addr[1]+15 : 16*addr[1]].
- Misaligned means:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- States:
  - IDLE: req_ready = 1; all other outputs idle.
  - ACCESS: memory read, or word write.
  - MERGE_WR: sub-word store write.
  - RESP: hold response until taken.
- IDLE, on accept (req_valid && req_ready):
  - Latch we, size, unsigned, addr, wdata.
  - Misaligned → RESP with resp_misalign = 1, resp_rdata = 0.
  - Otherwise → ACCESS.
- ACCESS (mem_addr = latched addr[DM_AW+1:2]):
  - Load: capture the extracted/extended lane of mem_rdata into resp_rdata → RESP.
  - Word store: mem_dmwr = 01, mem_wdata = latched wdata → RESP.
  - Sub-word store: merge latched wdata's low byte or half into mem_rdata at the lane, register the merged word, mem_dmwr = 00 → MERGE_WR.
- MERGE_WR: mem_dmwr = 01, mem_wdata = merged word, same mem_addr → RESP.
- RESP:
  - resp_valid = 1 and resp_rdata/resp_misalign are stable until resp_ready.
  - On resp_valid && resp_ready → IDLE.
  - No new request is accepted in RESP; req_ready = 0.
- Latency, from the accept edge to resp_valid (assuming resp_ready = 1):
  - load, word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned: 1 cycle.
- Address bits above DM_AW+1 are ignored, so addresses wrap modulo the memory size.
- req_ready is 0 in every state except IDLE.
- Reset (applies mid-operation too):
  - State returns to IDLE; any in-flight request is dropped with no response.
  - mem_dmwr is forced to 00 in any cycle where rst = 1, so a pending MERGE_WR write is abandoned and memory stays unmodified.
- Output values at reset:
  - req_ready = 1 (IDLE);
  - resp_valid = 0, resp_rdata = 0, resp_misalign = 0;
  - mem_dmwr = 00, mem_addr = 0, mem_wdata = 0.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;
  - DMWr codes DMWR_NONE = 2'b00, DMWR_WORD = 2'b01;
  - the state encoding (IDLE, ACCESS, MERGE_WR, RESP).
- One combinational sub-module, lsu_lane_mux, provides:
  - load extract/extend: inputs word, addr[1:0], size, unsigned;
  - store merge: inputs old word, wdata, addr[1:0], size.

Test Plan:
- Word store, then load: store 0xDEADBEEF at 0x10, then word load at 0x10 → mem_dmwr = 01 one cycle at mem_addr = 4; load returns 0xDEADBEEF, resp_valid 2 cycles after accept.
- Byte store: memory word 4 = 0x11223344, byte store wdata = 0x000000AB at 0x12 → one read cycle, then a single write 0x11AB3344; resp 3 cycles after accept.
- Sign/zero extension: word = 0x8001F0FF.
  - lb at 0x00 → 0xFFFFFFFF.
  - lbu at 0x00 → 0x000000FF.
  - lh at 0x02 → 0xFFFF8001.
  - lhu at 0x02 → 0x00008001.
- Misaligned: lh at 0x03 and sw at 0x06 → resp_misalign = 1, rdata = 0, 1 cycle after accept, mem_dmwr stays 00 throughout.
- Backpressure: resp_ready = 0 for 4 cycles after a load → resp_valid and resp_rdata held constant, req_ready = 0; a new req_valid is not accepted until the cycle after the response handshake.
- Reset mid-operation: assert rst during MERGE_WR of a halfword store → no write issued, memory word unchanged, next cycle state IDLE, req_ready = 1, resp_valid = 0.
